// File: rtl/intersection_scheduler.sv
// Four-approach traffic-light sequencer: round-robin green grants with
// min/max green timing, yellow and all-red clearance, emergency preemption.
//
// state  | meaning
// IDLE   | no demand, all approaches red
// GREEN  | approach cur has right of way, timer counts green cycles
// YELLOW | approach cur clearing, lasts YELLOW_T cycles
// ALLRED | intersection clearance, lasts ALLRED_T cycles
module intersection_scheduler #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emerg,
  input  logic [1:0] emerg_id,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] phase,
  output logic [1:0] cur
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_e;

  localparam logic [3:0] MIN_G = 4'(MIN_GREEN);
  localparam logic [3:0] MAX_G = 4'(MAX_GREEN);
  localparam logic [3:0] YEL_T = 4'(YELLOW_T);
  localparam logic [3:0] ARD_T = 4'(ALLRED_T);

  state_e     phase_q, phase_d;
  logic [1:0] cur_q, cur_d;
  logic [3:0] timer_q, timer_d;
  logic [3:0] green_q, yellow_q, red_q;

  logic [1:0] rr_win;
  logic       rr_any;
  logic       grant_any;
  logic [1:0] grant_id;
  logic [3:0] cur_onehot;
  logic       other_req;
  logic       handover;
  logic       preempt;

  // Scan from cur+4 down to cur+1 so the earliest position in round-robin
  // order is the last one assigned and therefore wins.
  always_comb begin
    rr_win = cur_q;
    rr_any = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[cur_q + 2'(k)]) begin
        rr_win = cur_q + 2'(k);
        rr_any = 1'b1;
      end
    end
  end

  assign grant_any  = emerg | rr_any;
  assign grant_id   = emerg ? emerg_id : rr_win;
  assign cur_onehot = 4'b0001 << cur_q;
  assign other_req  = |(req & ~cur_onehot);
  assign handover   = (timer_q >= MIN_G) && other_req &&
                      (!req[cur_q] || (timer_q == MAX_G));
  assign preempt    = emerg && (emerg_id != cur_q);

  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    case (phase_q)
      S_IDLE: begin
        timer_d = '0;
        if (grant_any) begin
          phase_d = S_GREEN;
          cur_d   = grant_id;
          timer_d = 4'd1;
        end
      end
      S_GREEN: begin
        // A matching emergency pins the green; the timer still advances.
        if (preempt || (!emerg && handover)) begin
          phase_d = S_YELLOW;
          timer_d = 4'd1;
        end else if (timer_q < MAX_G) begin
          timer_d = timer_q + 4'd1;
        end
      end
      S_YELLOW: begin
        if (timer_q >= YEL_T) begin
          phase_d = S_ALLRED;
          timer_d = 4'd1;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      S_ALLRED: begin
        if (timer_q >= ARD_T) begin
          if (grant_any) begin
            phase_d = S_GREEN;
            cur_d   = grant_id;
            timer_d = 4'd1;
          end else begin
            phase_d = S_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      default: begin
        phase_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Lamps decode the state held during the cycle, so they trail phase by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= S_IDLE;
      cur_q    <= 2'd0;
      timer_q  <= 4'd0;
      green_q  <= 4'b0000;
      yellow_q <= 4'b0000;
      red_q    <= 4'b1111;
    end else begin
      phase_q  <= phase_d;
      cur_q    <= cur_d;
      timer_q  <= timer_d;
      green_q  <= 4'b0000;
      yellow_q <= 4'b0000;
      red_q    <= 4'b1111;
      if (phase_q == S_GREEN) begin
        green_q <= cur_onehot;
        red_q   <= ~cur_onehot;
      end else if (phase_q == S_YELLOW) begin
        yellow_q <= cur_onehot;
        red_q    <= ~cur_onehot;
      end
    end
  end

  assign green  = green_q;
  assign yellow = yellow_q;
  assign red    = red_q;
  assign phase  = phase_q;
  assign cur    = cur_q;

endmodule
